fuzz_result_logger: RTL

Downstream consumer of the random fuzzer. It snoops the fuzzer's Wishbone master signals and status outputs, and folds each fuzzing run into one record: last applied addr/data, captured IP result, and sticky fault flags. Records are stored in an on-chip log FIFO for a host/debug reader. The block also maintains saturating run and fault statistics.

---
 rtl/fuzz_result_logger_pkg.sv | 29 ++
 rtl/fuzz_result_logger_fifo.sv | 73 +++++++
 rtl/fuzz_result_logger.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fuzz_result_logger_pkg.sv
// Shared types for the fuzz result logger: flag/record layouts and the logger FSM states.
// Record field widths are fixed here; the logger's CNT_WIDTH/READ_DATA_WIDTH must match them.
package fuzz_result_logger_pkg;

    localparam int REC_CNT_W    = 16;
    localparam int REC_RESULT_W = 32;

    typedef enum logic [1:0] {
        L_IDLE,
        L_RUN,
        L_COMMIT
    } log_state_e;

    typedef struct packed {
        logic no_txn;
        logic overflow;
        logic hang;
        logic crash;
    } fuzz_flags_t;

    typedef struct packed {
        logic [REC_CNT_W-1:0]    run_id;
        logic [31:0]             addr;
        logic [31:0]             data;
        logic [REC_RESULT_W-1:0] result;
        fuzz_flags_t             flags;
    } fuzz_log_record_t;

endpackage

// File: rtl/fuzz_result_logger_fifo.sv
// Synchronous show-ahead FIFO for log records; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module fuzz_result_logger_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  T                         din,
    input  logic                     pop,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != FULL_CNT) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fuzz_result_logger.sv
// Snoops the fuzzer bus/status, folds each run into one record, logs it and keeps run statistics.
// Optional FUZZ_LOG_IRQ_EN: registered fill/crash interrupt; otherwise irq is held at 0.
module fuzz_result_logger
    import fuzz_result_logger_pkg::*;
#(
    parameter int LOG_DEPTH       = 16,
    parameter int READ_DATA_WIDTH = REC_RESULT_W,
    parameter int CNT_WIDTH       = REC_CNT_W,
    parameter int LOG_ALL         = 0,
    parameter int IRQ_THRESHOLD   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         wb_cyc,
    input  logic                         wb_stb,
    input  logic                         wb_ack,
    input  logic [31:0]                  wb_addr,
    input  logic [31:0]                  wb_data,
    input  logic                         run_done,
    input  logic                         crash_detected,
    input  logic                         hang_detected,
    input  logic                         overflow_detected,
    input  logic [READ_DATA_WIDTH-1:0]   IP_output,
    input  logic                         rd_en,
    output logic                         rd_valid,
    output fuzz_log_record_t             rd_record,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_full,
    output logic [CNT_WIDTH-1:0]         run_cnt,
    output logic [CNT_WIDTH-1:0]         crash_cnt,
    output logic [CNT_WIDTH-1:0]         hang_cnt,
    output logic [CNT_WIDTH-1:0]         dropped_cnt,
    output logic                         irq
);

    localparam int CW = $clog2(LOG_DEPTH) + 1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    log_state_e                 state_q;
    logic [31:0]                last_addr_q, last_addr_d;
    logic [31:0]                last_data_q, last_data_d;
    logic [READ_DATA_WIDTH-1:0] result_q, result_d;
    fuzz_flags_t                flags_q, flags_d;
    logic [CNT_WIDTH-1:0]       run_cnt_q, run_cnt_d;
    logic [CNT_WIDTH-1:0]       crash_cnt_q, crash_cnt_d;
    logic [CNT_WIDTH-1:0]       hang_cnt_q, hang_cnt_d;
    logic [CNT_WIDTH-1:0]       dropped_cnt_q, dropped_cnt_d;

    fuzz_log_record_t           commit_rec;
    fuzz_log_record_t           fifo_dout;
    logic                       commit;
    logic                       qualify;
    logic                       push;
    logic                       pop_ok;
    logic                       wr_accept;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CW-1:0]              fifo_count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= L_IDLE;
        end else begin
            case (state_q)
                L_IDLE: begin
                    if (run_done) begin
                        state_q <= L_COMMIT;
                    end else if (wb_cyc) begin
                        state_q <= L_RUN;
                    end
                end
                L_RUN: begin
                    if (run_done) begin
                        state_q <= L_COMMIT;
                    end
                end
                default: state_q <= L_IDLE;
            endcase
        end
    end

    always_comb begin
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (wb_cyc && wb_stb && wb_ack) begin
            last_addr_d = wb_addr;
            last_data_d = wb_data;
        end
        case (state_q)
            L_IDLE: begin
                flags_d = '0;
                if (run_done) begin
                    flags_d.no_txn = 1'b1;
                    result_d       = IP_output;
                end
            end
            L_RUN: begin
                flags_d.crash    = flags_q.crash    | crash_detected;
                flags_d.hang     = flags_q.hang     | hang_detected;
                flags_d.overflow = flags_q.overflow | overflow_detected;
                if (run_done) begin
                    result_d = IP_output;
                end
            end
            default: flags_d = '0;
        endcase
    end

    assign commit  = (state_q == L_COMMIT);
    assign qualify = (LOG_ALL != 0) || (flags_q != '0);
    assign push    = commit && qualify;
    assign pop_ok  = rd_en && !fifo_empty;
    assign wr_accept = push && (!fifo_full || pop_ok);

    always_comb begin
        commit_rec.run_id = run_cnt_q;
        commit_rec.addr   = last_addr_q;
        commit_rec.data   = last_data_q;
        commit_rec.result = result_q;
        commit_rec.flags  = flags_q;
    end

    always_comb begin
        run_cnt_d     = run_cnt_q;
        crash_cnt_d   = crash_cnt_q;
        hang_cnt_d    = hang_cnt_q;
        dropped_cnt_d = dropped_cnt_q;
        if (commit) begin
            run_cnt_d = sat_inc(run_cnt_q);
            if (flags_q.crash) crash_cnt_d = sat_inc(crash_cnt_q);
            if (flags_q.hang)  hang_cnt_d  = sat_inc(hang_cnt_q);
            if (push && !wr_accept) dropped_cnt_d = sat_inc(dropped_cnt_q);
        end
    end

    // Address/data latches survive a soft clear; only a hard reset wipes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            result_q      <= '0;
            flags_q       <= '0;
            run_cnt_q     <= '0;
            crash_cnt_q   <= '0;
            hang_cnt_q    <= '0;
            dropped_cnt_q <= '0;
        end else begin
            result_q      <= result_d;
            flags_q       <= flags_d;
            run_cnt_q     <= run_cnt_d;
            crash_cnt_q   <= crash_cnt_d;
            hang_cnt_q    <= hang_cnt_d;
            dropped_cnt_q <= dropped_cnt_d;
        end
    end

    fuzz_result_logger_fifo #(
        .DEPTH (LOG_DEPTH),
        .T     (fuzz_log_record_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .push  (push),
        .din   (commit_rec),
        .pop   (rd_en),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rd_valid    = !fifo_empty;
    assign rd_record   = fifo_empty ? '0 : fifo_dout;
    assign log_count   = fifo_count;
    assign log_full    = fifo_full;
    assign run_cnt     = run_cnt_q;
    assign crash_cnt   = crash_cnt_q;
    assign hang_cnt    = hang_cnt_q;
    assign dropped_cnt = dropped_cnt_q;

`ifdef FUZZ_LOG_IRQ_EN
    logic          irq_q, irq_d;
    logic [CW-1:0] cnt_next;

    // Track next fill level so irq moves on the same edge as log_count.
    always_comb begin
        cnt_next = fifo_count;
        if (wr_accept && !pop_ok) begin
            cnt_next = fifo_count + CW'(1);
        end else if (!wr_accept && pop_ok) begin
            cnt_next = fifo_count - CW'(1);
        end
        irq_d = irq_q;
        if (cnt_next == '0) begin
            irq_d = 1'b0;
        end
        if ((int'(cnt_next) >= IRQ_THRESHOLD) || (wr_accept && commit_rec.flags.crash)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_cfg;
    assign unused_irq_cfg = (IRQ_THRESHOLD > 0);
    assign irq = 1'b0;
`endif

endmodule
